// File: rtl/player_anim_pkg.sv
// Shared types and sprite-sheet cell layout for the player sprite animator.
package player_anim_pkg;

    typedef enum logic [1:0] {IDLE, WALK, AIR, LAND} anim_state_t;

    localparam logic [3:0] STATUS_IDLE = 4'd0;
    localparam logic [3:0] STATUS_WALK = 4'd1;
    localparam logic [3:0] STATUS_AIR  = 4'd2;

    localparam logic [3:0] IDLE_BASE = 4'd0;
    localparam logic [3:0] WALK_BASE = 4'd4;
    localparam logic [3:0] RISE_CELL = 4'd10;
    localparam logic [3:0] FALL_CELL = 4'd11;
    localparam logic [3:0] LAND_BASE = 4'd12;

    localparam logic [2:0] IDLE_CELLS = 3'd4;
    localparam logic [2:0] WALK_CELLS = 3'd6;
    localparam logic [2:0] LAND_CELLS = 3'd3;

    function automatic logic [2:0] step_wrap(input logic [2:0] step, input logic [2:0] cells);
        return (step == cells - 3'd1) ? 3'd0 : step + 3'd1;
    endfunction

endpackage

// File: rtl/player_sprite_animator_addr_gen.sv
// Combinational pixel hit test and sprite-sheet address for the current draw pixel.
module sprite_addr_gen #(
    parameter int SPRITE_W = 28,
    parameter int SPRITE_H = 62,
    parameter int ADDR_W   = 15
) (
    input  logic [9:0]        player_x,
    input  logic [9:0]        player_y,
    input  logic [9:0]        player_sx,
    input  logic [9:0]        player_sy,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic [3:0]        frame_idx,
    input  logic              facing_left,
    output logic              is_player,
    output logic [ADDR_W-1:0] sprite_addr
);

    logic [9:0]        left, top, col, row, c;
    logic [ADDR_W-1:0] addr;

    always_comb begin
        // Box edges wrap at 10 bits, matching the player controller's arithmetic.
        left = player_x - {1'b0, player_sx[9:1]};
        top  = player_y - {1'b0, player_sy[9:1]};
        col  = draw_x - left;
        row  = draw_y - top;
        is_player = (draw_x >= left) && (col < player_sx) &&
                    (draw_y >= top)  && (row < player_sy) &&
                    (col < 10'(SPRITE_W)) && (row < 10'(SPRITE_H));
        c = facing_left ? (10'(SPRITE_W - 1) - col) : col;
        addr = ADDR_W'(frame_idx) * ADDR_W'(SPRITE_W * SPRITE_H)
             + ADDR_W'(row) * ADDR_W'(SPRITE_W)
             + ADDR_W'(c);
        sprite_addr = is_player ? addr : '0;
    end

endmodule

// File: rtl/player_sprite_animator.sv
// Player animation FSM, facing tracker and sprite address output.
// Horizontal mirroring is built only when PLAYER_MIRROR_EN is defined.
module player_sprite_animator
    import player_anim_pkg::*;
#(
    parameter int FRAME_DIV = 6,
    parameter int SPRITE_W  = 28,
    parameter int SPRITE_H  = 62,
    parameter int ADDR_W    = 15
) (
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [9:0]        PlayerX,
    input  logic [9:0]        PlayerY,
    input  logic [9:0]        PlayerSX,
    input  logic [9:0]        PlayerSY,
    input  logic [3:0]        PlayerStatus,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              is_player,
    output logic [ADDR_W-1:0] sprite_addr,
    output logic [3:0]        frame_idx,
    output logic              facing_left,
    output anim_state_t       anim_state
);

    localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    anim_state_t      state, state_next;
    logic [2:0]       step_q, step_next;
    logic [DIV_W-1:0] div_q, div_next;
    logic [3:0]       frame_next, status_eff;
    logic [9:0]       prev_y;
    logic             prev_valid, div_wrap, rising, falling;

    assign anim_state = state;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            step_q     <= '0;
            div_q      <= '0;
            frame_idx  <= IDLE_BASE;
            prev_y     <= '0;
            prev_valid <= 1'b0;
        end else begin
            state      <= state_next;
            step_q     <= step_next;
            div_q      <= div_next;
            frame_idx  <= frame_next;
            prev_y     <= PlayerY;
            prev_valid <= 1'b1;
        end
    end

    always_comb begin
        status_eff = (PlayerStatus > STATUS_AIR) ? STATUS_IDLE : PlayerStatus;
        div_wrap   = (div_q == DIV_LAST);
        rising     = prev_valid && (PlayerY < prev_y);
        falling    = prev_valid && (PlayerY > prev_y);

        state_next = state;
        case (status_eff)
            STATUS_WALK: state_next = WALK;
            STATUS_AIR:  state_next = AIR;
            default: begin
                case (state)
                    AIR:     state_next = LAND;
                    LAND:    state_next = (step_q == LAND_CELLS - 3'd1 && div_wrap) ? IDLE : LAND;
                    default: state_next = IDLE;
                endcase
            end
        endcase

        div_next  = div_wrap ? '0 : div_q + DIV_W'(1);
        step_next = step_q;
        if (state_next != state) begin
            div_next  = '0;
            step_next = '0;
        end else if (div_wrap) begin
            case (state)
                IDLE:    step_next = step_wrap(step_q, IDLE_CELLS);
                WALK:    step_next = step_wrap(step_q, WALK_CELLS);
                LAND:    step_next = (step_q < LAND_CELLS - 3'd1) ? step_q + 3'd1 : step_q;
                default: step_next = step_q;
            endcase
        end

        frame_next = frame_idx;
        case (state_next)
            IDLE: frame_next = IDLE_BASE + {1'b0, step_next};
            WALK: frame_next = WALK_BASE + {1'b0, step_next};
            LAND: frame_next = LAND_BASE + {1'b0, step_next};
            default: begin
                // Level flight keeps the last air cell; entering AIR level shows the rise cell.
                if (rising)             frame_next = RISE_CELL;
                else if (falling)       frame_next = FALL_CELL;
                else if (state != AIR)  frame_next = RISE_CELL;
            end
        endcase
    end

`ifdef PLAYER_MIRROR_EN
    logic [9:0] prev_x;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            prev_x      <= '0;
            facing_left <= 1'b0;
        end else begin
            prev_x <= PlayerX;
            if (prev_valid) begin
                if (PlayerX < prev_x)      facing_left <= 1'b1;
                else if (PlayerX > prev_x) facing_left <= 1'b0;
            end
        end
    end
`else
    assign facing_left = 1'b0;
`endif

    sprite_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .player_x    (PlayerX),
        .player_y    (PlayerY),
        .player_sx   (PlayerSX),
        .player_sy   (PlayerSY),
        .draw_x      (DrawX),
        .draw_y      (DrawY),
        .frame_idx   (frame_idx),
        .facing_left (facing_left),
        .is_player   (is_player),
        .sprite_addr (sprite_addr)
    );

endmodule

// File: tb/tb_player_sprite_animator.sv
// Scoreboard bench for player_sprite_animator with FRAME_DIV=4.
module tb_player_sprite_animator;
    import player_anim_pkg::*;

    localparam int FRAME_DIV = 4;
    localparam int SW = 28;
    localparam int SH = 62;
`ifdef PLAYER_MIRROR_EN
    localparam bit MIR = 1'b1;
`else
    localparam bit MIR = 1'b0;
`endif

    logic        Reset, frame_clk;
    logic [9:0]  PlayerX, PlayerY, PlayerSX, PlayerSY, DrawX, DrawY;
    logic [3:0]  PlayerStatus;
    logic        is_player, facing_left;
    logic [14:0] sprite_addr;
    logic [3:0]  frame_idx;
    anim_state_t anim_state;

    // Expected word: {facing_left, is_player, sprite_addr[14:0], frame_idx[3:0]}
    logic [20:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    player_sprite_animator #(.FRAME_DIV(FRAME_DIV)) dut (
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .PlayerX      (PlayerX),
        .PlayerY      (PlayerY),
        .PlayerSX     (PlayerSX),
        .PlayerSY     (PlayerSY),
        .PlayerStatus (PlayerStatus),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .is_player    (is_player),
        .sprite_addr  (sprite_addr),
        .frame_idx    (frame_idx),
        .facing_left  (facing_left),
        .anim_state   (anim_state)
    );

    // Clock and watchdog
    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic [3:0] st, input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] dx, input logic [9:0] dy);
        PlayerStatus = st;
        PlayerX = x;
        PlayerY = y;
        DrawX = dx;
        DrawY = dy;
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Scoreboard: push expected hit at (col,row) or miss, pop and compare on output.
    task automatic expect_px(input int frame, input bit fl, input int col, input int row);
        int c;
        int addr;
        c = fl ? (SW - 1 - col) : col;
        addr = frame * SW * SH + row * SW + c;
        exp_q.push_back({fl, 1'b1, addr[14:0], frame[3:0]});
    endtask

    task automatic expect_miss(input int frame, input bit fl);
        exp_q.push_back({fl, 1'b1 ^ 1'b1, 15'd0, frame[3:0]});
    endtask

    task automatic compare_out(input string tag);
        logic [20:0] e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_underflow"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_frame"},  {28'd0, frame_idx},   {28'd0, e[3:0]});
            check_val({tag, "_facing"}, {31'd0, facing_left}, {31'd0, e[20]});
            check_val({tag, "_hit"},    {31'd0, is_player},   {31'd0, e[19]});
            check_val({tag, "_addr"},   {17'd0, sprite_addr}, {17'd0, e[18:4]});
        end
    endtask

    initial begin
        Reset = 1'b1;
        PlayerSX = 10'd28;
        PlayerSY = 10'd62;
        drive(4'd0, 10'd320, 10'd377, 10'd306, 10'd346);
        #1;
        expect_px(0, 0, 0, 0);
        compare_out("reset");
        check_val("reset_state", {30'd0, anim_state}, {30'd0, IDLE});

        // Pixel boundaries at frame 0
        drive(4'd0, 10'd320, 10'd377, 10'd333, 10'd407); #1;
        expect_px(0, 0, 27, 61); compare_out("px_br");
        drive(4'd0, 10'd320, 10'd377, 10'd334, 10'd407); #1;
        expect_miss(0, 0); compare_out("px_right");
        drive(4'd0, 10'd320, 10'd377, 10'd305, 10'd346); #1;
        expect_miss(0, 0); compare_out("px_left");
        drive(4'd0, 10'd320, 10'd377, 10'd306, 10'd345); #1;
        expect_miss(0, 0); compare_out("px_top");
        drive(4'd0, 10'd320, 10'd377, 10'd306, 10'd408); #1;
        expect_miss(0, 0); compare_out("px_bottom");

        @(negedge frame_clk);
        Reset = 1'b0;

        // Walk cycle: cells 4..9 each FRAME_DIV edges, wrapping
        drive(4'd1, 10'd320, 10'd377, 10'd306, 10'd346);
        for (int n = 1; n <= 29; n++) begin
            tick();
            expect_px(4 + ((n - 1) / FRAME_DIV) % 6, 0, 0, 0);
            compare_out("walk");
        end

        // Facing: left, hold, right
        drive(4'd0, 10'd318, 10'd377, 10'd304, 10'd346);
        tick(); expect_px(0, MIR, 0, 0); compare_out("face_left");
        tick(); expect_px(0, MIR, 0, 0); compare_out("face_hold");
        drive(4'd0, 10'd322, 10'd377, 10'd308, 10'd346);
        tick(); expect_px(0, 0, 0, 0); compare_out("face_right");

        // Airborne rise, fall, level hold
        drive(4'd2, 10'd322, 10'd373, 10'd308, 10'd342);
        tick(); expect_px(10, 0, 0, 0); compare_out("air_rise");
        drive(4'd2, 10'd322, 10'd377, 10'd308, 10'd346);
        tick(); expect_px(11, 0, 0, 0); compare_out("air_fall");
        tick(); expect_px(11, 0, 0, 0); compare_out("air_hold");

        // Landing one-shot then idle
        drive(4'd0, 10'd322, 10'd377, 10'd308, 10'd346);
        for (int n = 1; n <= 13; n++) begin
            tick();
            expect_px((n < 5) ? 12 : (n < 9) ? 13 : (n < 13) ? 14 : 0, 0, 0, 0);
            compare_out("land");
        end

        // Landing interrupted by walk at cell 13
        drive(4'd2, 10'd322, 10'd375, 10'd308, 10'd344);
        tick(); expect_px(10, 0, 0, 0); compare_out("air_rise2");
        drive(4'd0, 10'd322, 10'd375, 10'd308, 10'd344);
        for (int n = 1; n <= 5; n++) begin
            tick();
            expect_px((n < 5) ? 12 : 13, 0, 0, 0);
            compare_out("land2");
        end
        drive(4'd1, 10'd322, 10'd375, 10'd308, 10'd344);
        tick(); expect_px(4, 0, 0, 0); compare_out("land_int");
        tick(); expect_px(4, 0, 0, 0); compare_out("walk2");
        drive(4'd1, 10'd320, 10'd375, 10'd306, 10'd344);
        tick(); expect_px(4, MIR, 0, 0); compare_out("walk_face");

        // Asynchronous reset mid-walk, no clock edge in between
        #2;
        Reset = 1'b1;
        #1;
        expect_px(0, 0, 0, 0);
        compare_out("reset_async");
        check_val("reset_async_state", {30'd0, anim_state}, {30'd0, IDLE});
        #5;
        Reset = 1'b0;

        check_val("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
